// File: rtl/sram_1r1w_param.sv
`default_nettype none
// ============================================================================
// Module   : sram_1r1w_param
// Purpose  : Parametrised 1R1W single-clock SRAM with lane write mask,
//            1/2-cycle read latency, collision policy and post-reset zero fill.
// Revision : 1.0
// ============================================================================
module sram_1r1w_param #(
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 64,
    parameter int MASK_GRAN = 8,
    parameter int READ_LAT  = 1,
    parameter int BYPASS    = 1,
    parameter int INIT_ZERO = 1
) (
    input  logic                           clock,
    input  logic                           reset_n,
    output logic                           init_done,
    input  logic                           W0_en,
    input  logic [ADDR_W-1:0]              W0_addr,
    input  logic [DATA_W-1:0]              W0_data,
    input  logic [DATA_W/MASK_GRAN-1:0]    W0_mask,
    input  logic                           R0_en,
    input  logic [ADDR_W-1:0]              R0_addr,
    output logic [DATA_W-1:0]              R0_data,
    output logic                           R0_valid
);

    localparam int               c_DEPTH = 2**ADDR_W;
    localparam int               c_NL    = DATA_W / MASK_GRAN;
    localparam logic [ADDR_W-1:0] c_LAST = '1;

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_cnt;
    logic                r_init_done;
    logic                w_fill;
    logic                w_wr;
    logic                w_rd;
    logic [DATA_W-1:0]   w_rd_word;
    logic [DATA_W-1:0]   r_rd_data;
    logic                r_rd_valid;
    logic [DATA_W-1:0]   r_mem [c_DEPTH];

    if ((READ_LAT != 1) && (READ_LAT != 2)) begin : g_bad_lat
        $fatal(1, "sram_1r1w_param: READ_LAT must be 1 or 2");
    end
    if ((DATA_W % MASK_GRAN) != 0) begin : g_bad_gran
        $fatal(1, "sram_1r1w_param: DATA_W must be a multiple of MASK_GRAN");
    end

    always_comb begin
        w_state_nxt = r_state;
        if ((r_state == S_CLEAR) && (r_cnt == c_LAST)) begin
            w_state_nxt = S_READY;
        end
    end

    // init_done follows the next state so it rises on the edge that writes the last entry
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= (INIT_ZERO != 0) ? S_CLEAR : S_READY;
            r_cnt       <= '0;
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_init_done <= (w_state_nxt == S_READY);
            if (r_state == S_CLEAR) begin
                r_cnt <= r_cnt + ADDR_W'(1);
            end
        end
    end

    assign w_fill = (r_state == S_CLEAR);
    assign w_wr   = r_init_done & W0_en;
    assign w_rd   = r_init_done & R0_en;

    always_ff @(posedge clock) begin
        if (w_fill) begin
            r_mem[r_cnt] <= '0;
        end else if (w_wr) begin
            for (int k = 0; k < c_NL; k++) begin
                if (W0_mask[k]) begin
                    r_mem[W0_addr][k*MASK_GRAN +: MASK_GRAN] <= W0_data[k*MASK_GRAN +: MASK_GRAN];
                end
            end
        end
    end

    // Same-edge collision: masked lanes forward the incoming data when write-first
    always_comb begin
        w_rd_word = r_mem[R0_addr];
        if ((BYPASS != 0) && w_wr && (W0_addr == R0_addr)) begin
            for (int k = 0; k < c_NL; k++) begin
                if (W0_mask[k]) begin
                    w_rd_word[k*MASK_GRAN +: MASK_GRAN] = W0_data[k*MASK_GRAN +: MASK_GRAN];
                end
            end
        end
    end

    if (READ_LAT == 2) begin : g_lat2
        logic [DATA_W-1:0] r_s1_data;
        logic              r_s1_valid;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                r_s1_data  <= '0;
                r_s1_valid <= 1'b0;
                r_rd_data  <= '0;
                r_rd_valid <= 1'b0;
            end else begin
                r_s1_valid <= w_rd;
                if (w_rd) begin
                    r_s1_data <= w_rd_word;
                end
                r_rd_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_rd_data <= r_s1_data;
                end
            end
        end
    end else begin : g_lat1
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                r_rd_data  <= '0;
                r_rd_valid <= 1'b0;
            end else begin
                r_rd_valid <= w_rd;
                if (w_rd) begin
                    r_rd_data <= w_rd_word;
                end
            end
        end
    end

    assign init_done = r_init_done;
    assign R0_data   = r_rd_data;
    assign R0_valid  = r_rd_valid;

endmodule
`default_nettype wire

// File: tb/tb_sram_1r1w_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_1r1w_param
// Purpose  : Randomised self-checking bench for sram_1r1w_param (three configs).
// Revision : 1.0
// ============================================================================
module tb_sram_1r1w_param;

    localparam int AW = 4;
    localparam int DW = 64;
    localparam int G  = 8;
    localparam int NL = DW / G;
    localparam int DEPTH = 2**AW;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          w0_en = 1'b0;
    logic [AW-1:0] w0_addr = '0;
    logic [DW-1:0] w0_data = '0;
    logic [NL-1:0] w0_mask = '0;
    logic          r0_en = 1'b0;
    logic [AW-1:0] r0_addr = '0;

    logic          init_a, init_b, init_c;
    logic [DW-1:0] data_a, data_b, data_c;
    logic          valid_a, valid_b, valid_c;

    int checks = 0;
    int errors = 0;

    // Reference state
    logic [DW-1:0] mem_m [DEPTH];
    int            rel_edges;
    logic [DW-1:0] hold_a, hold_b, pend_b;
    logic          pend_b_v, pend_c_v, exp_va, exp_vb, exp_vc;

    always #5 clock = ~clock;

    // A: latency 1, write-first.  B: latency 2, read-first.  C: no fill.
    sram_1r1w_param #(.ADDR_W(AW), .DATA_W(DW), .MASK_GRAN(G), .READ_LAT(1), .BYPASS(1), .INIT_ZERO(1)) dut_a (
        .clock(clock), .reset_n(reset_n), .init_done(init_a),
        .W0_en(w0_en), .W0_addr(w0_addr), .W0_data(w0_data), .W0_mask(w0_mask),
        .R0_en(r0_en), .R0_addr(r0_addr), .R0_data(data_a), .R0_valid(valid_a));

    sram_1r1w_param #(.ADDR_W(AW), .DATA_W(DW), .MASK_GRAN(G), .READ_LAT(2), .BYPASS(0), .INIT_ZERO(1)) dut_b (
        .clock(clock), .reset_n(reset_n), .init_done(init_b),
        .W0_en(w0_en), .W0_addr(w0_addr), .W0_data(w0_data), .W0_mask(w0_mask),
        .R0_en(r0_en), .R0_addr(r0_addr), .R0_data(data_b), .R0_valid(valid_b));

    sram_1r1w_param #(.ADDR_W(AW), .DATA_W(DW), .MASK_GRAN(G), .READ_LAT(2), .BYPASS(1), .INIT_ZERO(0)) dut_c (
        .clock(clock), .reset_n(reset_n), .init_done(init_c),
        .W0_en(w0_en), .W0_addr(w0_addr), .W0_data(w0_data), .W0_mask(w0_mask),
        .R0_en(r0_en), .R0_addr(r0_addr), .R0_data(data_c), .R0_valid(valid_c));

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        rel_edges = 0;
        hold_a = '0; hold_b = '0; pend_b = '0;
        pend_b_v = 1'b0; pend_c_v = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_init_a", {63'd0, init_a}, 64'd0);
        chk("rst_init_b", {63'd0, init_b}, 64'd0);
        chk("rst_init_c", {63'd0, init_c}, 64'd0);
        chk("rst_valid_a", {63'd0, valid_a}, 64'd0);
        chk("rst_valid_b", {63'd0, valid_b}, 64'd0);
        chk("rst_data_a", data_a, 64'd0);
        chk("rst_data_b", data_b, 64'd0);
        chk("rst_data_c", data_c, 64'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        model_reset();
    endtask

    // Drive one cycle, update the reference on the edge, check #1 later.
    task automatic step(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic [NL-1:0] wm, input logic re, input logic [AW-1:0] ra);
        logic          ready_ab, ready_c, acc_w, acc_r;
        logic [DW-1:0] old_w, res_a;
        w0_en = we; w0_addr = wa; w0_data = wd; w0_mask = wm;
        r0_en = re; r0_addr = ra;
        @(posedge clock);
        ready_ab = (rel_edges >= DEPTH);
        ready_c  = (rel_edges >= 1);
        acc_w = we & ready_ab;
        acc_r = re & ready_ab;
        old_w = mem_m[ra];
        res_a = old_w;
        for (int k = 0; k < NL; k++) begin
            if (acc_w && wm[k]) begin
                if (wa == ra) res_a[k*G +: G] = wd[k*G +: G];
                mem_m[wa][k*G +: G] = wd[k*G +: G];
            end
        end
        exp_va = acc_r;
        if (acc_r) hold_a = res_a;
        exp_vb = pend_b_v;
        if (pend_b_v) hold_b = pend_b;
        pend_b_v = acc_r;
        if (acc_r) pend_b = old_w;
        exp_vc = pend_c_v;
        pend_c_v = re & ready_c;
        if (rel_edges < 1000) rel_edges++;
        #1;
        chk("init_a", {63'd0, init_a}, {63'd0, rel_edges >= DEPTH});
        chk("init_b", {63'd0, init_b}, {63'd0, rel_edges >= DEPTH});
        chk("init_c", {63'd0, init_c}, {63'd0, rel_edges >= 1});
        chk("valid_a", {63'd0, valid_a}, {63'd0, exp_va});
        chk("valid_b", {63'd0, valid_b}, {63'd0, exp_vb});
        chk("valid_c", {63'd0, valid_c}, {63'd0, exp_vc});
        chk("data_a", data_a, hold_a);
        chk("data_b", data_b, hold_b);
        @(negedge clock);
    endtask

    task automatic rnd_step();
        logic [AW-1:0] wa, ra;
        logic [NL-1:0] wm;
        wa = AW'($urandom_range(0, DEPTH-1));
        ra = ($urandom_range(0, 9) < 3) ? wa : AW'($urandom_range(0, DEPTH-1));
        case ($urandom_range(0, 3))
            0:       wm = '1;
            1:       wm = '0;
            default: wm = NL'($urandom);
        endcase
        step(1'($urandom), wa, {$urandom, $urandom}, wm, 1'($urandom), ra);
    endtask

    initial begin
        model_reset();
        do_reset();
        // Enables pulsed during the fill, then a reset part-way through it
        repeat (7) rnd_step();
        do_reset();
        repeat (DEPTH) rnd_step();
        for (int a = 0; a < DEPTH; a++) step(1'b0, '0, '0, '0, 1'b1, AW'(a));

        step(1'b1, 4'd3, 64'h1122334455667788, 8'hFF, 1'b0, '0);
        step(1'b1, 4'd3, 64'hAA00000000000000, 8'h80, 1'b0, '0);
        step(1'b0, '0, '0, '0, 1'b1, 4'd3);
        chk("merge_lat1", data_a, 64'hAA22334455667788);
        step(1'b0, '0, '0, '0, 1'b0, '0);
        chk("merge_lat2", data_b, 64'hAA22334455667788);

        step(1'b1, 4'd5, 64'hFFFFFFFFFFFFFFFF, 8'h0F, 1'b1, 4'd5);
        chk("coll_write_first", data_a, 64'h00000000FFFFFFFF);
        step(1'b0, '0, '0, '0, 1'b0, '0);
        chk("coll_read_first", data_b, 64'h0);
        chk("coll_read_first_v", {63'd0, valid_b}, 64'd1);

        for (int a = 1; a <= 3; a++) step(1'b0, '0, '0, '0, 1'b1, AW'(a));
        repeat (3) step(1'b0, '0, '0, '0, 1'b0, '0);

        repeat (800) rnd_step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
